// File: rtl/sump_cmd_assembler.sv
// Groups UART bytes into SUMP short (1-byte) and long (opcode + 4 data bytes)
// commands and presents them on a single-entry valid/ready output register.
module sump_cmd_assembler #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit MSB_FIRST      = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        cmd_long,
    output logic        timeout_err,
    output logic        overrun_err,
    input  logic        clear_err
);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_cnt;
    logic [7:0]      r_op;
    logic [31:0]     r_shift;
    logic [TW-1:0]   r_tcnt;

    logic            w_hs, w_load_short, w_start_long, w_take_byte, w_load_long;
    logic            w_timeout, w_overrun;
    logic [1:0]      w_pos;
    logic [31:0]     w_payload;

    assign w_hs      = cmd_valid & cmd_ready;
    assign w_pos     = MSB_FIRST ? (2'd3 - r_cnt) : r_cnt;
    // A byte arriving in the limit cycle wins over the timeout.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_COLLECT) &&
                       !rx_valid && (r_tcnt == TLIM);

    always_comb begin
        w_payload = r_shift;
        w_payload[{w_pos, 3'b000} +: 8] = rx_data;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_short = 1'b0;
        w_start_long = 1'b0;
        w_take_byte  = 1'b0;
        w_load_long  = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            S_IDLE, S_HOLD: begin
                // HOLD behaves as IDLE on the handshake cycle so back-to-back bytes are not lost.
                if (r_state == S_HOLD && !w_hs) begin
                    w_overrun = rx_valid;
                end else begin
                    if (r_state == S_HOLD) w_state_nxt = S_IDLE;
                    if (rx_valid) begin
                        if (rx_data[7]) begin
                            w_start_long = 1'b1;
                            w_state_nxt  = S_COLLECT;
                        end else begin
                            w_load_short = 1'b1;
                            w_state_nxt  = S_HOLD;
                        end
                    end
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    w_take_byte = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_load_long = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_op        <= 8'd0;
            r_shift     <= 32'd0;
            r_tcnt      <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= 8'd0;
            cmd_data    <= 32'd0;
            cmd_long    <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            cmd_valid <= (w_state_nxt == S_HOLD);
            if (w_load_short) begin
                cmd_opcode <= rx_data;
                cmd_data   <= 32'd0;
                cmd_long   <= 1'b0;
            end
            if (w_start_long) begin
                r_op    <= rx_data;
                r_shift <= 32'd0;
                r_cnt   <= 2'd0;
            end
            if (w_take_byte) begin
                r_shift <= w_payload;
                r_cnt   <= r_cnt + 2'd1;
            end
            if (w_load_long) begin
                cmd_opcode <= r_op;
                cmd_data   <= w_payload;
                cmd_long   <= 1'b1;
            end
            if (r_state == S_COLLECT && !rx_valid && !w_timeout)
                r_tcnt <= r_tcnt + 1'b1;
            else
                r_tcnt <= '0;
            if (w_timeout)      timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
            if (w_overrun)      overrun_err <= 1'b1;
            else if (clear_err) overrun_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sump_cmd_assembler.sv
// Directed bench: two instances (LSB-first and MSB-first payload order) share
// all inputs; inputs change and outputs are sampled on the falling clock edge.
module tb_sump_cmd_assembler;
    logic        clock = 1'b0;
    logic        reset, rx_valid, cmd_ready, clear_err;
    logic [7:0]  rx_data;
    logic        v0, v1, l0, l1, te0, te1, oe0, oe1;
    logic [7:0]  op0, op1;
    logic [31:0] d0, d1;
    int          n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    sump_cmd_assembler #(.TIMEOUT_CYCLES(50), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(v0), .cmd_ready(cmd_ready), .cmd_opcode(op0), .cmd_data(d0),
        .cmd_long(l0), .timeout_err(te0), .overrun_err(oe0), .clear_err(clear_err));

    sump_cmd_assembler #(.TIMEOUT_CYCLES(50), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(v1), .cmd_ready(cmd_ready), .cmd_opcode(op1), .cmd_data(d1),
        .cmd_long(l1), .timeout_err(te1), .overrun_err(oe1), .clear_err(clear_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] seq5 [6];
        seq5 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        reset = 1'b1; rx_valid = 1'b0; cmd_ready = 1'b0; clear_err = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_valid", {31'd0, v0 | v1}, 32'd0);
        chk("rst_op", {24'd0, op0}, 32'd0);
        chk("rst_data", d0, 32'd0);
        chk("rst_err", {30'd0, te0 | te1, oe0 | oe1}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // short command, immediate handshake
        cmd_ready = 1'b1;
        send(8'h02);
        chk("s_valid", {31'd0, v0}, 32'd1);
        chk("s_op", {24'd0, op0}, 32'h02);
        chk("s_long", {31'd0, l0}, 32'd0);
        chk("s_data", d0, 32'd0);
        @(negedge clock);
        chk("s_valid_fall", {31'd0, v0}, 32'd0);
        chk("s_err", {30'd0, te0, oe0}, 32'd0);

        // long command, both byte orders
        cmd_ready = 1'b0;
        send(8'hC2); send(8'h00); send(8'h00); send(8'h00);
        chk("l_not_yet", {31'd0, v0}, 32'd0);
        send(8'h08);
        chk("l_valid", {30'd0, v0, v1}, 32'd3);
        chk("l_op", {24'd0, op0}, 32'hC2);
        chk("l_long", {30'd0, l0, l1}, 32'd3);
        chk("l_data_lsb", d0, 32'h0800_0000);
        chk("l_data_msb", d1, 32'h0000_0008);
        cmd_ready = 1'b1;
        @(negedge clock);
        chk("l_hs", {31'd0, v0}, 32'd0);

        // overrun while output stalled
        cmd_ready = 1'b0;
        send(8'h81); send(8'hFF); send(8'h00); send(8'hFF); send(8'h00);
        chk("o_data_lsb", d0, 32'h00FF_00FF);
        chk("o_data_msb", d1, 32'hFF00_FF00);
        chk("o_no_err", {31'd0, oe0}, 32'd0);
        send(8'h01);
        chk("o_hold_valid", {31'd0, v0}, 32'd1);
        chk("o_hold_op", {24'd0, op0}, 32'h81);
        chk("o_hold_data", d0, 32'h00FF_00FF);
        chk("o_err", {31'd0, oe0}, 32'd1);
        cmd_ready = 1'b1;
        @(negedge clock);
        chk("o_hs", {31'd0, v0}, 32'd0);
        chk("o_err_sticky", {31'd0, oe0}, 32'd1);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        chk("o_err_clr", {31'd0, oe0}, 32'd0);

        // timeout of a partial long command
        cmd_ready = 1'b0;
        send(8'hC0); send(8'h00);
        for (int i = 0; i < 60; i++) begin
            if (v0) chk("t_spurious_valid", {31'd0, v0}, 32'd0);
            @(negedge clock);
        end
        chk("t_err", {30'd0, te0, te1}, 32'd3);
        chk("t_no_valid", {31'd0, v0}, 32'd0);
        cmd_ready = 1'b1;
        send(8'h01);
        chk("t_next_valid", {31'd0, v0}, 32'd1);
        chk("t_next_op", {24'd0, op0}, 32'h01);
        chk("t_next_long", {31'd0, l0}, 32'd0);
        @(negedge clock);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        chk("t_err_clr", {31'd0, te0}, 32'd0);

        // back-to-back short commands captured on handshake cycles
        for (int i = 0; i < 6; i++) begin
            send(seq5[i]);
            chk($sformatf("b2b_valid%0d", i), {31'd0, v0}, 32'd1);
            chk($sformatf("b2b_op%0d", i), {24'd0, op0}, {24'd0, seq5[i]});
        end
        @(negedge clock);
        chk("b2b_done", {31'd0, v0}, 32'd0);
        chk("b2b_no_ovr", {31'd0, oe0}, 32'd0);

        // reset mid long command
        send(8'hC5); send(8'h11); send(8'h22);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("r_no_valid", {31'd0, v0}, 32'd0);
        send(8'h80); send(8'h00); send(8'h00); send(8'h00);
        chk("r_not_yet", {31'd0, v0}, 32'd0);
        send(8'h00);
        chk("r_valid", {31'd0, v0}, 32'd1);
        chk("r_op", {24'd0, op0}, 32'h80);
        chk("r_long", {31'd0, l0}, 32'd1);
        chk("r_data", d0, 32'd0);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sump_cmd_assembler.md
Name: sump_cmd_assembler

Overview:
- Sits between the UART receiver byte output and the SUMP core command decoder inside Logic_Sniffer.
- Groups incoming bytes into SUMP commands:
  - short: 1 byte, opcode bit7 = 0;
  - long: opcode byte with bit7 = 1, followed by 4 data bytes.
- Presents each complete command on a one-entry valid/ready output register.
- Aborts partial long commands after an inter-byte timeout, and flags bytes lost while the output is stalled.

Parameters:
TIMEOUT_CYCLES, 1000000, clock cycles without a new byte before a partial long command is discarded; 0 disables the timeout
MSB_FIRST, 0, 0: first data byte -> data[7:0] (SUMP wire order); 1: first data byte -> data[31:24]

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
cmd_valid  out  1  command register holds an unconsumed command
cmd_ready  in  1  consumer accepts command when cmd_valid & cmd_ready
cmd_opcode  out  8  opcode byte
cmd_data  out  32  long-command payload; 0 for short commands
cmd_long  out  1  1 = long command
timeout_err  out  1  sticky; set when a partial long command is discarded by timeout
overrun_err  out  1  sticky; set when a byte is dropped
clear_err  in  1  clears both sticky flags (set wins on the same cycle)

Behaviour:
- Reset (synchronous):
  - all outputs 0, state IDLE, byte counter 0, timeout counter 0.
  - reset asserted mid-command discards the partial command with no output.
- States: IDLE, COLLECT (bytes 1..4), HOLD (output full).
- IDLE, rx_valid:
  - rx_data[7] = 0: load cmd_opcode = rx_data, cmd_data = 0, cmd_long = 0, go to HOLD. cmd_valid rises the cycle after the rx_valid strobe (latency 1).
  - rx_data[7] = 1: latch opcode, clear the payload shift register, count = 0, go to COLLECT.
- COLLECT, rx_valid: place the byte by count.
  - MSB_FIRST = 0: byte n occupies bits [8n+7:8n].
  - MSB_FIRST = 1: byte n occupies bits [31-8n:24-8n].
  - count increments; on the 4th byte, present opcode, data and cmd_long = 1, go to HOLD. cmd_valid rises the cycle after the 4th strobe.
- HOLD:
  - cmd_valid = 1; outputs stable until the handshake.
  - On cmd_valid & cmd_ready: cmd_valid falls next cycle, return to IDLE.
  - rx_valid in the same cycle as the handshake: the byte is processed as in IDLE (back-to-back commands with no loss).
  - rx_valid without the handshake: byte dropped, overrun_err set, state unchanged.
- Timeout:
  - The counter runs only in COLLECT and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: discard the partial command, set timeout_err, go to IDLE.
  - rx_valid in the same cycle the counter reaches its limit: the byte is accepted and the counter clears; no timeout.
- Short opcodes, including 0x00 reset, 0x01 run, 0x02 id, 0x04 metadata and 0x11/0x13 xon/xoff, are all passed through unchanged.
  - No opcode-specific handling is done here.
  - Five consecutive 0x00 bytes therefore produce five short commands.
- cmd_data, cmd_opcode and cmd_long change only on the load into HOLD.
- Sticky flags:
  - timeout_err and overrun_err hold until clear_err or reset.
  - When clear_err and a set event fall in the same cycle, the flag is left set.

Test Plan:
- Reset then byte 0x02, cmd_ready = 1 -> one-cycle cmd_valid, cmd_opcode = 0x02, cmd_long = 0, cmd_data = 0; errors stay 0.
- Bytes C2,00,00,00,08 with MSB_FIRST = 0 -> cmd_opcode = 0xC2, cmd_long = 1, cmd_data = 0x08000000. Same bytes with MSB_FIRST = 1 -> cmd_data = 0x00000008.
- Bytes 81,FF,00,FF,00 with cmd_ready = 0, then byte 0x01 before the handshake -> the 0x81 command is held unchanged, the 0x01 byte is dropped, overrun_err = 1. Raising cmd_ready completes the 0x81 handshake; clear_err then drops overrun_err.
- TIMEOUT_CYCLES = 50: bytes C0,00 then idle 60 cycles -> timeout_err = 1, no cmd_valid. Next byte 0x01 -> short command 0x01.
- Five 0x00 bytes, then 0x02, with cmd_ready tied 1 -> six short commands in order, 0x00 ×5 then 0x02. A byte arriving on the handshake cycle is captured (no overrun).
- Reset asserted after byte 3 of a long command -> no output and a clean IDLE. A subsequent full 80,00,00,00,00 yields cmd_data = 0, cmd_long = 1.
